pcm_modport: RTL and testbench

Dual-channel (left/right) PCM sample buffer between the Acortex audio front end and the Fgyrus FFT engine. Acortex writes stereo sample pairs through a shared address port; Fgyrus reads them back with a fixed pipeline latency. A ready flag announces a full frame. A delayed copy of the address is provided so the reader can tag returned data.

---
 rtl/pcm_modport.sv | 106 ++++++++++
 tb/tb_pcm_modport.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pcm_modport.sv
// rtl/pcm_modport.sv - dual-channel PCM sample buffer with fixed-latency pipelined read
// Optional overrun detection is built when PCM_MODPORT_OVRN_DET_EN is defined.
module pcm_modport #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 7,
   parameter int RD_DELAY = 2
) (
   input  logic              clk_ir,
   input  logic              rst_il,
   input  logic [ADDR_W-1:0] pcm_addr,
   input  logic              pcm_wren,
   input  logic [DATA_W-1:0] lpcm_wdata,
   input  logic [DATA_W-1:0] rpcm_wdata,
   input  logic              pcm_rden,
   output logic [DATA_W-1:0] lpcm_rdata,
   output logic [DATA_W-1:0] rpcm_rdata,
   output logic              pcm_rd_valid,
   output logic [ADDR_W-1:0] pcm_raddr,
   output logic              pcm_data_rdy,
   output logic              pcm_ovrn
);
   localparam int                DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

   logic [DATA_W-1:0] mem_l [DEPTH];
   logic [DATA_W-1:0] mem_r [DEPTH];

   logic [DATA_W-1:0] l_pipe     [RD_DELAY];
   logic [DATA_W-1:0] r_pipe     [RD_DELAY];
   logic [ADDR_W-1:0] raddr_pipe [RD_DELAY];
   logic [RD_DELAY-1:0] vld_pipe;
   logic                rd_acc;
   logic                data_rdy;

   // A simultaneous write wins; the read is silently dropped.
   assign rd_acc = pcm_rden & ~pcm_wren;

   always_ff @(posedge clk_ir) begin
      if (pcm_wren) begin
         mem_l[pcm_addr] <= lpcm_wdata;
         mem_r[pcm_addr] <= rpcm_wdata;
      end
   end

   // The last stage only loads on a valid result so the outputs hold between pulses.
   always_ff @(posedge clk_ir or posedge rst_il) begin
      if (rst_il) begin
         vld_pipe <= '0;
         for (int i = 0; i < RD_DELAY; i++) begin
            l_pipe[i]     <= '0;
            r_pipe[i]     <= '0;
            raddr_pipe[i] <= '0;
         end
      end else begin
         vld_pipe[0]   <= rd_acc;
         raddr_pipe[0] <= pcm_addr;
         if (RD_DELAY > 1 || rd_acc) begin
            l_pipe[0] <= mem_l[pcm_addr];
            r_pipe[0] <= mem_r[pcm_addr];
         end
         for (int i = 1; i < RD_DELAY; i++) begin
            vld_pipe[i]   <= vld_pipe[i-1];
            raddr_pipe[i] <= raddr_pipe[i-1];
            if (i < RD_DELAY-1 || vld_pipe[i-1]) begin
               l_pipe[i] <= l_pipe[i-1];
               r_pipe[i] <= r_pipe[i-1];
            end
         end
      end
   end

   assign lpcm_rdata   = l_pipe[RD_DELAY-1];
   assign rpcm_rdata   = r_pipe[RD_DELAY-1];
   assign pcm_rd_valid = vld_pipe[RD_DELAY-1];
   assign pcm_raddr    = raddr_pipe[RD_DELAY-1];

   always_ff @(posedge clk_ir or posedge rst_il) begin
      if (rst_il) begin
         data_rdy <= 1'b0;
      end else if (pcm_wren && pcm_addr == LAST_ADDR) begin
         data_rdy <= 1'b1;
      end else if (rd_acc && pcm_addr == LAST_ADDR) begin
         data_rdy <= 1'b0;
      end
   end

   assign pcm_data_rdy = data_rdy;

`ifdef PCM_MODPORT_OVRN_DET_EN
   logic ovrn;

   // Acortex overwrote a frame Fgyrus has not finished reading.
   always_ff @(posedge clk_ir or posedge rst_il) begin
      if (rst_il) begin
         ovrn <= 1'b0;
      end else if (pcm_wren && data_rdy) begin
         ovrn <= 1'b1;
      end
   end

   assign pcm_ovrn = ovrn;
`else
   assign pcm_ovrn = 1'b0;
`endif

endmodule

// File: tb/tb_pcm_modport.sv
// tb/tb_pcm_modport.sv - randomized bench for pcm_modport at read latencies 1, 2 and 4
// Model: per-edge history of accepted reads; expected outputs derived from latency arithmetic.
module tb_pcm_modport;
   localparam int DW   = 32;
   localparam int AW   = 7;
   localparam int MAXC = 4096;
   localparam logic [AW-1:0] LAST = {AW{1'b1}};

   logic          clk_ir = 1'b0;
   logic          rst_il = 1'b1;
   logic [AW-1:0] pcm_addr = '0;
   logic          pcm_wren = 1'b0;
   logic          pcm_rden = 1'b0;
   logic [DW-1:0] lpcm_wdata = '0;
   logic [DW-1:0] rpcm_wdata = '0;

   logic [DW-1:0] l_q   [3];
   logic [DW-1:0] r_q   [3];
   logic          v_q   [3];
   logic [AW-1:0] ra_q  [3];
   logic          rdy_q [3];
   logic          ov_q  [3];

   int dly_tab [3] = '{1, 2, 4};

   always #5 clk_ir = ~clk_ir;

   pcm_modport #(.DATA_W(DW), .ADDR_W(AW), .RD_DELAY(1)) u_d1 (
      .clk_ir(clk_ir), .rst_il(rst_il), .pcm_addr(pcm_addr), .pcm_wren(pcm_wren),
      .lpcm_wdata(lpcm_wdata), .rpcm_wdata(rpcm_wdata), .pcm_rden(pcm_rden),
      .lpcm_rdata(l_q[0]), .rpcm_rdata(r_q[0]), .pcm_rd_valid(v_q[0]),
      .pcm_raddr(ra_q[0]), .pcm_data_rdy(rdy_q[0]), .pcm_ovrn(ov_q[0]));

   pcm_modport #(.DATA_W(DW), .ADDR_W(AW), .RD_DELAY(2)) u_d2 (
      .clk_ir(clk_ir), .rst_il(rst_il), .pcm_addr(pcm_addr), .pcm_wren(pcm_wren),
      .lpcm_wdata(lpcm_wdata), .rpcm_wdata(rpcm_wdata), .pcm_rden(pcm_rden),
      .lpcm_rdata(l_q[1]), .rpcm_rdata(r_q[1]), .pcm_rd_valid(v_q[1]),
      .pcm_raddr(ra_q[1]), .pcm_data_rdy(rdy_q[1]), .pcm_ovrn(ov_q[1]));

   pcm_modport #(.DATA_W(DW), .ADDR_W(AW), .RD_DELAY(4)) u_d4 (
      .clk_ir(clk_ir), .rst_il(rst_il), .pcm_addr(pcm_addr), .pcm_wren(pcm_wren),
      .lpcm_wdata(lpcm_wdata), .rpcm_wdata(rpcm_wdata), .pcm_rden(pcm_rden),
      .lpcm_rdata(l_q[2]), .rpcm_rdata(r_q[2]), .pcm_rd_valid(v_q[2]),
      .pcm_raddr(ra_q[2]), .pcm_data_rdy(rdy_q[2]), .pcm_ovrn(ov_q[2]));

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: sample memory plus a log of what happened at each edge.
   logic [DW-1:0] m_l [1<<AW];
   logic [DW-1:0] m_r [1<<AW];
   bit            acc_h [MAXC];
   logic [DW-1:0] l_h   [MAXC];
   logic [DW-1:0] r_h   [MAXC];
   logic [AW-1:0] a_h   [MAXC];
   int            n         = 0;
   int            rst_start = 1;
   bit            m_rdy     = 1'b0;
   bit            m_ovrn    = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, n, got, exp);
      end
   endtask

   task automatic check_all();
      int            j;
      bit            ev;
      logic [DW-1:0] el, er;
      logic [AW-1:0] ea;
      for (int k = 0; k < 3; k++) begin
         j  = n - dly_tab[k] + 1;
         ev = 1'b0;
         ea = '0;
         el = '0;
         er = '0;
         if (j >= rst_start) begin
            ev = acc_h[j];
            ea = a_h[j];
         end
         for (int i = j; i >= rst_start; i--) begin
            if (acc_h[i]) begin
               el = l_h[i];
               er = r_h[i];
               break;
            end
         end
         check_eq($sformatf("valid_d%0d", dly_tab[k]), 64'(v_q[k]), 64'(ev));
         check_eq($sformatf("ldata_d%0d", dly_tab[k]), 64'(l_q[k]), 64'(el));
         check_eq($sformatf("rdata_d%0d", dly_tab[k]), 64'(r_q[k]), 64'(er));
         check_eq($sformatf("raddr_d%0d", dly_tab[k]), 64'(ra_q[k]), 64'(ea));
         check_eq($sformatf("rdy_d%0d", dly_tab[k]), 64'(rdy_q[k]), 64'(m_rdy));
         check_eq($sformatf("ovrn_d%0d", dly_tab[k]), 64'(ov_q[k]), 64'(m_ovrn));
      end
   endtask

   task automatic check_zero(input string tag);
      for (int k = 0; k < 3; k++) begin
         check_eq($sformatf("%s_valid_d%0d", tag, dly_tab[k]), 64'(v_q[k]), 64'd0);
         check_eq($sformatf("%s_ldata_d%0d", tag, dly_tab[k]), 64'(l_q[k]), 64'd0);
         check_eq($sformatf("%s_rdata_d%0d", tag, dly_tab[k]), 64'(r_q[k]), 64'd0);
         check_eq($sformatf("%s_raddr_d%0d", tag, dly_tab[k]), 64'(ra_q[k]), 64'd0);
         check_eq($sformatf("%s_rdy_d%0d", tag, dly_tab[k]), 64'(rdy_q[k]), 64'd0);
         check_eq($sformatf("%s_ovrn_d%0d", tag, dly_tab[k]), 64'(ov_q[k]), 64'd0);
      end
   endtask

   // Called at a falling edge: drive, take one rising edge, update model, check.
   task automatic cycle(input bit we, input bit re, input logic [AW-1:0] a,
                        input logic [DW-1:0] l, input logic [DW-1:0] r);
      pcm_wren   = we;
      pcm_rden   = re;
      pcm_addr   = a;
      lpcm_wdata = l;
      rpcm_wdata = r;
      @(posedge clk_ir);
      n++;
      acc_h[n] = re && !we;
      a_h[n]   = a;
      if (acc_h[n]) begin
         l_h[n] = m_l[a];
         r_h[n] = m_r[a];
      end
      if (we) begin
`ifdef PCM_MODPORT_OVRN_DET_EN
         if (m_rdy) m_ovrn = 1'b1;
`endif
         m_l[a] = l;
         m_r[a] = r;
         if (a == LAST) m_rdy = 1'b1;
      end else if (re && a == LAST) begin
         m_rdy = 1'b0;
      end
      @(negedge clk_ir);
      check_all();
   endtask

   task automatic idle(input int cnt);
      for (int i = 0; i < cnt; i++) cycle(1'b0, 1'b0, AW'($urandom), $urandom, $urandom);
   endtask

   task automatic do_reset();
      pcm_wren = 1'b0;
      pcm_rden = 1'b0;
      rst_il   = 1'b1;
      #1;
      check_zero("async_rst");
      @(posedge clk_ir);
      n++;
      acc_h[n]  = 1'b0;
      a_h[n]    = pcm_addr;
      m_rdy     = 1'b0;
      m_ovrn    = 1'b0;
      rst_start = n + 1;
      @(negedge clk_ir);
      rst_il = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk_ir);
      check_zero("init_rst");
      rst_il = 1'b0;

      // Single write / readback at address 5
      cycle(1'b1, 1'b0, 7'd5, 32'h1111_1111, 32'h2222_2222);
      cycle(1'b0, 1'b1, 7'd5, 32'h0, 32'h0);
      idle(5);

      // Full frame streaming in and out
      for (int a = 0; a < 128; a++) cycle(1'b1, 1'b0, AW'(a), DW'(a), ~DW'(a));
      for (int a = 0; a < 128; a++) cycle(1'b0, 1'b1, AW'(a), $urandom, $urandom);
      idle(5);

      // Write/read collision, then read-after-write
      cycle(1'b1, 1'b1, 7'd9, 32'hAAAA_5555, 32'h5555_AAAA);
      cycle(1'b0, 1'b1, 7'd9, 32'h0, 32'h0);
      idle(5);

      // Overrun: overwrite while a frame is pending
      cycle(1'b1, 1'b0, LAST, $urandom, $urandom);
      cycle(1'b1, 1'b0, 7'd0, $urandom, $urandom);
      for (int a = 0; a < 8; a++) cycle(1'b0, 1'b1, AW'(a), $urandom, $urandom);
      cycle(1'b0, 1'b1, LAST, $urandom, $urandom);
      idle(5);

      // Random traffic, biased toward the frame-end address
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
               ($urandom_range(0, 7) == 0) ? LAST : AW'($urandom), $urandom, $urandom);
      end

      // Reset with reads in flight, then confirm memory survived
      for (int a = 10; a < 14; a++) cycle(1'b0, 1'b1, AW'(a), $urandom, $urandom);
      do_reset();
      idle(6);
      for (int a = 10; a < 14; a++) cycle(1'b0, 1'b1, AW'(a), $urandom, $urandom);
      cycle(1'b0, 1'b1, 7'd5, $urandom, $urandom);
      idle(5);

      for (int i = 0; i < 200; i++) begin
         cycle($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
               ($urandom_range(0, 5) == 0) ? LAST : AW'($urandom), $urandom, $urandom);
      end
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
